// File: rtl/frame_rx_deframer_if.sv
// FIFO write-port bundle between the deframer (master) and the read FIFO (slave).
interface frame_rx_deframer_if;
  logic [7:0] dout;
  logic [1:0] dtype;
  logic       dout_we;
  logic       fifo_full;

  modport master (output dout, output dtype, output dout_we, input fifo_full);
  modport slave  (input dout, input dtype, input dout_we, output fifo_full);
endinterface

// File: rtl/frame_rx_deframer.sv
// Receive-side deframer: aligns on K28.5 idles, recovers SOF/EOF framed payload
// and writes each byte with a first/middle/last/abort tag into the read FIFO.
// Every byte is held back one character so the last one can be tagged on EOF.
module frame_rx_deframer #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8,
  parameter int MAX_LEN    = 256
) (
  input  logic                       read_clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_charisk,
  input  logic                       rx_code_err,
  frame_rx_deframer_if.master        fifo,
  output logic                       link_ready,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                err_cnt
);

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOF  = 8'hFB;
  localparam logic [7:0] K_EOF  = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t      state_r, state_nx;
  logic [15:0] lock_r, lock_nx, loss_r, loss_nx, len_r, len_nx;
  logic [7:0]  hold_r, hold_nx, dout_r, dout_nx;
  logic [1:0]  dtype_r, dtype_nx, tag_s;
  logic        first_r, first_nx, we_r, we_nx, err_r, ready_r, ready_nx;
  logic [15:0] frame_cnt_r, err_cnt_r;
  logic        good_s, idle_s, sof_s, eof_s, data_s;
  logic        lose_s, wr_s, err_s, done_s, ovf_s;

  // Character classification; code errors and empty cycles count as bad.
  always_comb begin
    good_s = rx_valid & ~rx_code_err;
    idle_s = good_s & rx_charisk & (rx_data == K_IDLE);
    sof_s  = good_s & rx_charisk & (rx_data == K_SOF);
    eof_s  = good_s & rx_charisk & (rx_data == K_EOF);
    data_s = good_s & ~rx_charisk;
  end

  // Lock/loss counters and the link_ready decision for this character.
  always_comb begin
    lock_nx  = 16'd0;
    loss_nx  = 16'd0;
    ready_nx = ready_r;
    lose_s   = 1'b0;
    if (idle_s) begin
      lock_nx = (lock_r == 16'hFFFF) ? lock_r : lock_r + 16'd1;
    end else begin
      lock_nx = 16'd0;
    end
    if (!good_s) begin
      loss_nx = (loss_r == 16'hFFFF) ? loss_r : loss_r + 16'd1;
    end else begin
      loss_nx = 16'd0;
    end
    if (ready_r) begin
      if (loss_nx >= 16'(LOSS_COUNT)) begin
        ready_nx = 1'b0;
        lose_s   = 1'b1;
      end else begin
        ready_nx = 1'b1;
      end
    end else begin
      ready_nx = (lock_nx >= 16'(LOCK_COUNT)) ? 1'b1 : 1'b0;
    end
  end

  // Frame FSM next state, holdback update and write/error decisions.
  always_comb begin
    state_nx = state_r;
    hold_nx  = hold_r;
    first_nx = first_r;
    len_nx   = len_r;
    wr_s     = 1'b0;
    tag_s    = 2'b00;
    err_s    = 1'b0;
    done_s   = 1'b0;
    ovf_s    = 1'b0;
    if (lose_s) begin
      // Link dropped: close any open frame with an abort terminator.
      state_nx = ST_IDLE;
      if (state_r == ST_HOLD) begin
        wr_s  = 1'b1;
        tag_s = 2'b11;
        err_s = 1'b1;
      end else begin
        wr_s = 1'b0;
      end
    end else if (ready_r && good_s && !idle_s) begin
      case (state_r)
        ST_IDLE: begin
          if (sof_s) begin
            state_nx = ST_OPEN;
          end else if (data_s || eof_s) begin
            err_s = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_OPEN: begin
          if (data_s) begin
            state_nx = ST_HOLD;
            hold_nx  = rx_data;
            first_nx = 1'b1;
            len_nx   = 16'd1;
          end else if (sof_s) begin
            err_s = 1'b1;
          end else begin
            err_s    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_HOLD: begin
          wr_s = 1'b1;
          if (data_s) begin
            if (len_r >= 16'(MAX_LEN)) begin
              tag_s    = 2'b11;
              err_s    = 1'b1;
              state_nx = ST_DISCARD;
            end else begin
              tag_s    = first_r ? 2'b01 : 2'b00;
              hold_nx  = rx_data;
              first_nx = 1'b0;
              len_nx   = len_r + 16'd1;
            end
          end else if (eof_s) begin
            tag_s    = 2'b10;
            done_s   = 1'b1;
            state_nx = ST_IDLE;
          end else if (sof_s) begin
            tag_s    = 2'b11;
            err_s    = 1'b1;
            state_nx = ST_OPEN;
          end else begin
            tag_s    = 2'b11;
            err_s    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (sof_s) begin
            state_nx = ST_OPEN;
          end else if (eof_s) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_DISCARD;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = state_r;
    end
    // A write that the FIFO cannot take is dropped and the frame discarded.
    if (wr_s && fifo.fifo_full) begin
      ovf_s  = 1'b1;
      err_s  = 1'b1;
      done_s = 1'b0;
      if (!lose_s) begin
        state_nx = ST_DISCARD;
      end else begin
        state_nx = ST_IDLE;
      end
    end else begin
      ovf_s = 1'b0;
    end
    we_nx    = wr_s & ~ovf_s;
    dout_nx  = we_nx ? hold_r : dout_r;
    dtype_nx = we_nx ? tag_s : dtype_r;
  end

  // Frame FSM state register.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath, link state and registered outputs.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r      <= 16'd0;
      loss_r      <= 16'd0;
      ready_r     <= 1'b0;
      hold_r      <= 8'd0;
      first_r     <= 1'b0;
      len_r       <= 16'd0;
      dout_r      <= 8'd0;
      dtype_r     <= 2'b00;
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= 16'd0;
      err_cnt_r   <= 16'd0;
    end else begin
      lock_r      <= lock_nx;
      loss_r      <= loss_nx;
      ready_r     <= ready_nx;
      hold_r      <= hold_nx;
      first_r     <= first_nx;
      len_r       <= len_nx;
      dout_r      <= dout_nx;
      dtype_r     <= dtype_nx;
      we_r        <= we_nx;
      err_r       <= err_s;
      frame_cnt_r <= (done_s && frame_cnt_r != 16'hFFFF) ? frame_cnt_r + 16'd1 : frame_cnt_r;
      err_cnt_r   <= (err_s && err_cnt_r != 16'hFFFF) ? err_cnt_r + 16'd1 : err_cnt_r;
    end
  end

  assign fifo.dout    = dout_r;
  assign fifo.dtype   = dtype_r;
  assign fifo.dout_we = we_r;
  assign link_ready   = ready_r;
  assign frame_err    = err_r;
  assign frame_cnt    = frame_cnt_r;
  assign err_cnt      = err_cnt_r;

endmodule
